// File: rtl/p12_pkg.sv
// Shared types for the p12 rotatable logic tile: orientation commands, the
// orientation triple, the reset LUT contents and the command transfer function.
package p12_pkg;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_FLIPV     = 3'd1,
        CMD_FLIPH     = 3'd2,
        CMD_TRANSPOSE = 3'd3,
        CMD_ROT_CW    = 3'd4,
        CMD_ROT_CCW   = 3'd5,
        CMD_NOP6      = 3'd6,
        CMD_IDENT     = 3'd7
    } cmd_e;

    localparam logic [3:0] LUT_NAND = 4'b0111;

    typedef struct packed {
        logic d;
        logic v;
        logic h;
    } orient_t;

    // Group action of one command on the current orientation.
    function automatic orient_t apply_cmd(input orient_t o, input cmd_e c);
        orient_t n;
        n = o;
        case (c)
            CMD_FLIPV:     n.v = ~o.v;
            CMD_FLIPH:     n.h = ~o.h;
            CMD_TRANSPOSE: n = '{d: ~o.d, v: o.h,  h: o.v};
            CMD_ROT_CW:    n = '{d: ~o.d, v: o.h,  h: ~o.v};
            CMD_ROT_CCW:   n = '{d: ~o.d, v: ~o.h, h: o.v};
            CMD_IDENT:     n = '0;
            default:       n = o;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/p12_orient.sv
// Orientation register {d,v,h}: head of the config chain, also updated in
// place by group commands when the chain is not shifting.
module p12_orient
    import p12_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_en_i,
    input  logic       cfg_in_i,
    input  logic       cmd_valid_i,
    input  logic [2:0] cmd_i,
    output orient_t    orient_o,
    output logic       cfg_bit_o
);

    orient_t orient_q, orient_d;

    // A shift always wins; a command arriving with it is simply dropped.
    always_comb begin
        orient_d = orient_q;
        if (cfg_en_i) begin
            orient_d = '{d: orient_q.v, v: orient_q.h, h: cfg_in_i};
        end else if (cmd_valid_i) begin
            orient_d = apply_cmd(orient_q, cmd_e'(cmd_i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            orient_q <= '0;
        end else begin
            orient_q <= orient_d;
        end
    end

    assign orient_o  = orient_q;
    assign cfg_bit_o = orient_q.d;

endmodule

// File: rtl/p12_tile_lanes.sv
// W-lane rotatable logic tile: per-lane 4-entry LUT plus state flop, with
// orientation-dependent side mapping and an optional registered loop breaker.
module p12_tile_lanes
    import p12_pkg::*;
#(
    parameter int W       = 4,
    parameter int LB_MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         se,
    input  logic         sc_in,
    output logic         sc_out,
    input  logic         cfg_en,
    input  logic         cfg_in,
    output logic         cfg_out,
    input  logic         cmd_valid,
    input  logic [2:0]   cmd,
    input  logic         lb,
    input  logic [W-1:0] in_t,
    input  logic [W-1:0] in_r,
    input  logic [W-1:0] in_b,
    input  logic [W-1:0] in_l,
    output logic [W-1:0] out_t,
    output logic [W-1:0] out_r,
    output logic [W-1:0] out_b,
    output logic [W-1:0] out_l
);

    orient_t        orient;
    logic           cfg_bit;
    logic [4*W-1:0] lut_q, lut_d;
    logic [W-1:0]   st_q, st_d;
    logic [W-1:0]   gn_q, gh_q;
    logic [W-1:0]   f, dh, dv, gn, gh;

    p12_orient u_orient (
        .clk         (clk),
        .rst         (rst),
        .cfg_en_i    (cfg_en),
        .cfg_in_i    (cfg_in),
        .cmd_valid_i (cmd_valid),
        .cmd_i       (cmd),
        .orient_o    (orient),
        .cfg_bit_o   (cfg_bit)
    );

    // LUT bit 4*i+j is lut[i][j]; the chain enters at lut[0][0] from d.
    always_comb begin
        lut_d = lut_q;
        if (cfg_en) begin
            lut_d = {lut_q[4*W-2:0], cfg_bit};
        end
    end

    always_comb begin
        st_d[0] = se ? sc_in : dv[0];
        for (int i = 1; i < W; i++) begin
            st_d[i] = se ? st_q[i-1] : dv[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lut_q <= {W{LUT_NAND}};
            st_q  <= '0;
            gn_q  <= '0;
            gh_q  <= '0;
        end else begin
            lut_q <= lut_d;
            st_q  <= st_d;
            if (!lb) begin
                gn_q <= f;
                gh_q <= dh;
            end
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_lane
        logic [3:0] lane_lut;
        logic       vt, vb, hr, hl, oh, ov;

        // Unmap physical sides back to the upright frame.
        assign vt = orient.v ? in_b[i] : in_t[i];
        assign vb = orient.v ? in_t[i] : in_b[i];
        assign hr = orient.h ? in_l[i] : in_r[i];
        assign hl = orient.h ? in_r[i] : in_l[i];

        assign lane_lut = lut_q[4*i +: 4];
        assign f[i]     = lane_lut[{hr, vb}];
        assign dh[i]    = orient.d ? vt : hl;
        assign dv[i]    = orient.d ? hl : vt;

        assign gn[i] = (LB_MODE == 1) ? gn_q[i] : f[i];
        assign gh[i] = (LB_MODE == 1) ? gh_q[i] : dh[i];

        assign oh = orient.d ? gn[i] : st_q[i];
        assign ov = orient.d ? st_q[i] : gn[i];

        assign out_t[i] = orient.v ? gh[i] : ov;
        assign out_b[i] = orient.v ? ov : gh[i];
        assign out_r[i] = orient.h ? oh : gh[i];
        assign out_l[i] = orient.h ? gh[i] : oh;
    end

    assign sc_out  = st_q[W-1];
    assign cfg_out = lut_q[4*W-1];

endmodule

// File: tb/tb_p12_tile_lanes.sv
// Self-checking bench for p12_tile_lanes: a bypass instance and a loop-breaker
// instance share stimulus and are compared against a flat config-memory model.
module tb_p12_tile_lanes;
    import p12_pkg::*;

    localparam int W = 4;
    localparam int N = 3 + 4 * W;

    logic         clk = 1'b0;
    logic         rst, se, sc_in, cfg_en, cfg_in, cmd_valid, lb;
    logic [2:0]   cmd;
    logic [W-1:0] in_t, in_r, in_b, in_l;
    logic [W-1:0] o0_t, o0_r, o0_b, o0_l, o1_t, o1_r, o1_b, o1_l;
    logic         sc0, sc1, cf0, cf1;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: m_cfg[0]=h, [1]=v, [2]=d, [3+4i+j]=lut[i][j], in chain order.
    logic [N-1:0] m_cfg;
    logic [W-1:0] m_st, m_hn, m_hh;

    always #5 clk = ~clk;

    p12_tile_lanes #(.W(W), .LB_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .se(se), .sc_in(sc_in), .sc_out(sc0),
        .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cf0),
        .cmd_valid(cmd_valid), .cmd(cmd), .lb(lb),
        .in_t(in_t), .in_r(in_r), .in_b(in_b), .in_l(in_l),
        .out_t(o0_t), .out_r(o0_r), .out_b(o0_b), .out_l(o0_l)
    );

    p12_tile_lanes #(.W(W), .LB_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .se(se), .sc_in(sc_in), .sc_out(sc1),
        .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cf1),
        .cmd_valid(cmd_valid), .cmd(cmd), .lb(lb),
        .in_t(in_t), .in_r(in_r), .in_b(in_b), .in_l(in_l),
        .out_t(o1_t), .out_r(o1_r), .out_b(o1_b), .out_l(o1_l)
    );

    function automatic logic [N-1:0] reset_cfg();
        logic [N-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) c[3+4*i +: 4] = 4'b0111;
        return c;
    endfunction

    // Returns {f, dh, dv} for lane i under the model's current orientation.
    function automatic logic [2:0] lane(input int i);
        logic d, v, h, t, r, b, l, vt, vb, hr, hl;
        d = m_cfg[2]; v = m_cfg[1]; h = m_cfg[0];
        t = in_t[i]; r = in_r[i]; b = in_b[i]; l = in_l[i];
        vt = v ? b : t; vb = v ? t : b;
        hr = h ? l : r; hl = h ? r : l;
        return {m_cfg[3 + 4*i + 2*int'(hr) + int'(vb)], d ? vt : hl, d ? hl : vt};
    endfunction

    function automatic logic [4*W+1:0] expect_outs(input bit hold);
        logic [W-1:0] et, er, eb, el;
        logic [2:0]   x;
        logic         d, v, h, gn, gh, oh, ov;
        d = m_cfg[2]; v = m_cfg[1]; h = m_cfg[0];
        for (int i = 0; i < W; i++) begin
            x  = lane(i);
            gn = hold ? m_hn[i] : x[2];
            gh = hold ? m_hh[i] : x[1];
            oh = d ? gn : m_st[i];
            ov = d ? m_st[i] : gn;
            et[i] = v ? gh : ov;
            eb[i] = v ? ov : gh;
            er[i] = h ? oh : gh;
            el[i] = h ? gh : oh;
        end
        return {et, er, eb, el, m_st[W-1], m_cfg[N-1]};
    endfunction

    function automatic logic [4*W+1:0] observed(input bit inst);
        if (inst) return {o1_t, o1_r, o1_b, o1_l, sc1, cf1};
        return {o0_t, o0_r, o0_b, o0_l, sc0, cf0};
    endfunction

    // Advance one clock edge, stepping the model with the pre-edge inputs.
    task automatic tick();
        logic [N-1:0] c_n;
        logic [W-1:0] st_n, hn_n, hh_n;
        logic [2:0]   x;
        logic         d, v, h;
        c_n = m_cfg; st_n = m_st; hn_n = m_hn; hh_n = m_hh;
        if (rst) begin
            c_n = reset_cfg(); st_n = '0; hn_n = '0; hh_n = '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                x = lane(i);
                st_n[i] = se ? ((i == 0) ? sc_in : m_st[i-1]) : x[0];
                if (!lb) begin
                    hn_n[i] = x[2];
                    hh_n[i] = x[1];
                end
            end
            d = m_cfg[2]; v = m_cfg[1]; h = m_cfg[0];
            if (cfg_en) begin
                c_n = {m_cfg[N-2:0], cfg_in};
            end else if (cmd_valid) begin
                case (cmd)
                    3'd1: v = ~v;
                    3'd2: h = ~h;
                    3'd3: {d, v, h} = {~m_cfg[2], m_cfg[0], m_cfg[1]};
                    3'd4: {d, v, h} = {~m_cfg[2], m_cfg[0], ~m_cfg[1]};
                    3'd5: {d, v, h} = {~m_cfg[2], ~m_cfg[0], m_cfg[1]};
                    3'd7: {d, v, h} = 3'b000;
                    default: ;
                endcase
                c_n[2:0] = {d, v, h};
            end
        end
        @(posedge clk);
        m_cfg = c_n; m_st = st_n; m_hn = hn_n; m_hh = hh_n;
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; se = 1'b0; sc_in = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0;
        cmd_valid = 1'b0; cmd = 3'd0; lb = 1'b0;
        in_t = '0; in_r = '0; in_b = '0; in_l = '0;
    endtask

    task automatic rand_sides();
        in_t = W'($urandom); in_r = W'($urandom);
        in_b = W'($urandom); in_l = W'($urandom);
    endtask

    task automatic run_cmd(input cmd_e c);
        cmd_valid = 1'b1; cmd = c;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        in_r = '1; in_b = '1; #1;
        n_tests++;
        if (o0_t !== 4'h0 || o0_l !== 4'h0 || sc0 !== 1'b0 || cf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_nand11: got t=%h l=%h sc=%b cfg=%b expected t=0 l=0 sc=0 cfg=0",
                     o0_t, o0_l, sc0, cf0);
        end
        in_r = '0; #1;
        n_tests++;
        if (o0_t !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_nand01: got out_t=%h expected F", o0_t);
        end
        n_tests++;
        if (observed(1) !== expect_outs(1)) begin
            n_fail++;
            $display("FAIL reset_lb_inst: got %h expected %h", observed(1), expect_outs(1));
        end
    endtask

    // Compares group equivalences with st pinned to 0 via scan, so outputs
    // depend only on orientation and inputs.
    task automatic test_orient_group();
        logic [4*W-1:0] vec [4];
        logic [4*W+1:0] cap [4];
        idle_inputs();
        se = 1'b1; sc_in = 1'b0;
        for (int k = 0; k < 4; k++) vec[k] = (4*W)'($urandom);
        run_cmd(CMD_IDENT);
        for (int k = 0; k < W; k++) tick();
        for (int k = 0; k < 4; k++) begin
            {in_t, in_r, in_b, in_l} = vec[k]; #1;
            cap[k] = observed(0);
        end
        for (int r = 0; r < 4; r++) begin
            run_cmd(CMD_ROT_CW);
            n_tests++;
            if (observed(0) !== expect_outs(0)) begin
                n_fail++;
                $display("FAIL rot_cw_step%0d: got %h expected %h", r, observed(0), expect_outs(0));
            end
        end
        for (int k = 0; k < 4; k++) begin
            {in_t, in_r, in_b, in_l} = vec[k]; #1;
            n_tests++;
            if (observed(0) !== cap[k]) begin
                n_fail++;
                $display("FAIL rot_cw_x4_vec%0d: got %h expected %h", k, observed(0), cap[k]);
            end
        end
        run_cmd(CMD_TRANSPOSE);
        run_cmd(CMD_TRANSPOSE);
        for (int k = 0; k < 4; k++) begin
            {in_t, in_r, in_b, in_l} = vec[k]; #1;
            n_tests++;
            if (observed(0) !== cap[k]) begin
                n_fail++;
                $display("FAIL transpose_x2_vec%0d: got %h expected %h", k, observed(0), cap[k]);
            end
        end
        run_cmd(CMD_FLIPV);
        run_cmd(CMD_FLIPH);
        for (int k = 0; k < 4; k++) begin
            {in_t, in_r, in_b, in_l} = vec[k]; #1;
            cap[k] = observed(0);
        end
        run_cmd(CMD_IDENT);
        run_cmd(CMD_ROT_CW);
        run_cmd(CMD_ROT_CW);
        for (int k = 0; k < 4; k++) begin
            {in_t, in_r, in_b, in_l} = vec[k]; #1;
            n_tests++;
            if (observed(0) !== cap[k] || cap[k] !== expect_outs(0)) begin
                n_fail++;
                $display("FAIL flipvh_vs_rot180_vec%0d: got %h flipvh %h expected %h",
                         k, observed(0), cap[k], expect_outs(0));
            end
        end
    endtask

    task automatic test_cfg_chain();
        logic [N-1:0] pat;
        idle_inputs();
        pat = '0;
        for (int i = 0; i < W; i++) pat[3+4*i+3] = 1'b1;
        cfg_en = 1'b1;
        for (int k = 0; k < N; k++) begin
            cfg_in = pat[N-1-k];
            tick();
        end
        cfg_en = 1'b0;
        in_r = 4'hA; in_b = 4'hF; #1;
        n_tests++;
        if (o0_t !== 4'hA) begin
            n_fail++;
            $display("FAIL cfg_and_lut: got out_t=%h expected A", o0_t);
        end
        n_tests++;
        if (observed(0) !== expect_outs(0)) begin
            n_fail++;
            $display("FAIL cfg_and_model: got %h expected %h", observed(0), expect_outs(0));
        end
        cfg_en = 1'b1;
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (cf0 !== pat[N-1-k]) begin
                n_fail++;
                $display("FAIL cfg_out_bit%0d: got %b expected %b", k, cf0, pat[N-1-k]);
            end
            cfg_in = 1'($urandom);
            tick();
        end
        cfg_en = 1'b0;
    endtask

    task automatic test_scan();
        logic [3:0] seq;
        idle_inputs();
        seq = 4'b1101;
        se = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sc_in = seq[k];
            tick();
        end
        sc_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (sc0 !== seq[k]) begin
                n_fail++;
                $display("FAIL scan_out%0d: got %b expected %b", k, sc0, seq[k]);
            end
            tick();
        end
        se = 1'b0;
        run_cmd(CMD_IDENT);
        in_t = 4'h5;
        tick();
        n_tests++;
        if (o0_l !== 4'h5) begin
            n_fail++;
            $display("FAIL state_load: got out_l=%h expected 5", o0_l);
        end
    endtask

    task automatic test_loop_breaker();
        idle_inputs();
        run_cmd(CMD_IDENT);
        tick();
        lb = 1'b1; in_l = '1;
        tick(); tick();
        n_tests++;
        if (o1_r !== 4'h0 || o0_r !== 4'hF) begin
            n_fail++;
            $display("FAIL lb_hold: got lb_r=%h byp_r=%h expected lb_r=0 byp_r=F", o1_r, o0_r);
        end
        lb = 1'b0; #1;
        n_tests++;
        if (o1_r !== 4'h0) begin
            n_fail++;
            $display("FAIL lb_release_pre_edge: got %h expected 0", o1_r);
        end
        tick();
        n_tests++;
        if (o1_r !== 4'hF) begin
            n_fail++;
            $display("FAIL lb_release: got %h expected F", o1_r);
        end
    endtask

    task automatic test_cmd_during_cfg();
        idle_inputs();
        run_cmd(CMD_IDENT);
        cfg_en = 1'b1; cfg_in = 1'b0; cmd_valid = 1'b1; cmd = CMD_ROT_CW;
        tick();
        idle_inputs();
        in_l = '1; in_t = '0; #1;
        n_tests++;
        if (o0_b !== 4'hF) begin
            n_fail++;
            $display("FAIL cmd_dropped_in_cfg: got out_b=%h expected F", o0_b);
        end
        n_tests++;
        if (observed(0) !== expect_outs(0) || observed(1) !== expect_outs(1)) begin
            n_fail++;
            $display("FAIL cmd_dropped_model: got %h/%h expected %h/%h",
                     observed(0), observed(1), expect_outs(0), expect_outs(1));
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [N-1:0] rc;
        idle_inputs();
        cfg_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cfg_in = 1'($urandom);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; cfg_en = 1'b0;
        in_r = '1; in_b = '1; #1;
        n_tests++;
        if (o0_t !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_mid_shift_nand: got out_t=%h expected 0", o0_t);
        end
        rc = reset_cfg();
        cfg_en = 1'b1;
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (cf0 !== rc[N-1-k]) begin
                n_fail++;
                $display("FAIL rst_mid_shift_cfg%0d: got %b expected %b", k, cf0, rc[N-1-k]);
            end
            cfg_in = 1'b0;
            tick();
        end
        cfg_en = 1'b0;
    endtask

    task automatic test_random();
        idle_inputs();
        for (int k = 0; k < 400; k++) begin
            rst       = ($urandom_range(63, 0) == 0);
            se        = 1'($urandom);
            sc_in     = 1'($urandom);
            cfg_en    = ($urandom_range(7, 0) == 0);
            cfg_in    = 1'($urandom);
            cmd_valid = 1'($urandom);
            cmd       = 3'($urandom);
            lb        = 1'($urandom);
            rand_sides(); #1;
            n_tests++;
            if (observed(0) !== expect_outs(0) || observed(1) !== expect_outs(1)) begin
                n_fail++;
                $display("FAIL rand_comb%0d: got %h/%h expected %h/%h", k,
                         observed(0), observed(1), expect_outs(0), expect_outs(1));
            end
            tick();
            n_tests++;
            if (observed(0) !== expect_outs(0) || observed(1) !== expect_outs(1)) begin
                n_fail++;
                $display("FAIL rand_edge%0d: got %h/%h expected %h/%h", k,
                         observed(0), observed(1), expect_outs(0), expect_outs(1));
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_cfg = '0; m_st = '0; m_hn = '0; m_hh = '0;
        idle_inputs();
        test_reset();
        test_orient_group();
        test_cfg_chain();
        test_scan();
        test_loop_breaker();
        test_cmd_during_cfg();
        test_reset_mid_shift();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
